// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch data hazard detection with stall counter.
// Define HAZARD_STALL_PERF_EN to add the stall_cycles performance counter.
module hazard_stall_unit #(
  parameter int REG_AW             = 5,
  parameter int CNT_W              = 3,
  parameter int LOAD_USE_STALLS    = 1,
  parameter int BRANCH_ALU_STALLS  = 1,
  parameter int BRANCH_LOAD_STALLS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_mem_read,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_noop,
  output logic              ifid_flush,
  output logic              stall_active,
  output logic [31:0]       stall_cycles
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  localparam int BM_I = (BRANCH_LOAD_STALLS >= 2) ?
                        BRANCH_LOAD_STALLS - 1 : 0;

  localparam logic [CNT_W-1:0] LU_N = CNT_W'(LOAD_USE_STALLS);
  localparam logic [CNT_W-1:0] BA_N = CNT_W'(BRANCH_ALU_STALLS);
  localparam logic [CNT_W-1:0] BL_N = CNT_W'(BRANCH_LOAD_STALLS);
  localparam logic [CNT_W-1:0] BM_N = CNT_W'(BM_I);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_req;
  logic             ex_hit, mem_hit;
  logic             lu_hit, ba_hit, bl_hit, bm_hit;
  logic             detect, stall_raw;

  assign ex_hit =
    (id_use_rs && (id_rs != '0) && (id_rs == ex_rd)) ||
    (id_use_rt && (id_rt != '0) && (id_rt == ex_rd));

  assign mem_hit =
    (id_use_rs && (id_rs != '0) && (id_rs == mem_rd)) ||
    (id_use_rt && (id_rt != '0) && (id_rt == mem_rd));

  assign lu_hit = ex_mem_read && ex_hit && !id_is_branch;
  assign ba_hit = id_is_branch && ex_reg_write &&
                  !ex_mem_read && ex_hit;
  assign bl_hit = id_is_branch && ex_mem_read && ex_hit;
  assign bm_hit = id_is_branch && mem_mem_read && mem_hit;

  // Overlapping hazards cost the largest count, never the sum.
  always_comb begin
    n_req = '0;
    if (lu_hit && (LU_N > n_req)) n_req = LU_N;
    if (ba_hit && (BA_N > n_req)) n_req = BA_N;
    if (bl_hit && (BL_N > n_req)) n_req = BL_N;
    if (bm_hit && (BM_N > n_req)) n_req = BM_N;
  end

  assign detect    = (state_q == S_IDLE) && (n_req != '0);
  assign stall_raw = detect || (state_q == S_STALL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (n_req > ONE) begin
          cnt_d   = n_req - ONE;
          state_d = S_STALL;
        end
      end
      (state_q == S_STALL): begin
        if (cnt_q == ONE) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset only gates the outputs; the flops are already cleared asynchronously.
  assign pc_write     = !rst_n || !stall_raw;
  assign ifid_write   = !rst_n || !stall_raw;
  assign idex_noop    = rst_n && stall_raw;
  assign ifid_flush   = rst_n && id_branch_taken && !stall_raw;
  assign stall_active = (state_q == S_STALL);

`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall_raw && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench with a per-cycle stall-budget model
// driving three parameterisations of hazard_stall_unit in parallel.
module tb_hazard_stall_unit;

`ifdef HAZARD_STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int LU[3] = '{1, 2, 0};
  localparam int BA[3] = '{1, 3, 0};
  localparam int BL[3] = '{2, 4, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, id_is_branch, id_branch_taken;
  logic       ex_reg_write, ex_mem_read, mem_mem_read;

  logic [2:0]  pcw, ifw, noop, flush, sa;
  logic [31:0] sc [3];

  typedef struct {
    logic        pcw, ifw, noop, flush, sa;
    logic [31:0] sc;
  } out_t;

  out_t sb[$];
  int   rem[3];
  int   cnt[3];
  int   tests = 0;
  int   fails = 0;

  hazard_stall_unit u0 (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .pc_write(pcw[0]), .ifid_write(ifw[0]),
    .idex_noop(noop[0]), .ifid_flush(flush[0]),
    .stall_active(sa[0]), .stall_cycles(sc[0])
  );

  hazard_stall_unit #(
    .LOAD_USE_STALLS(2), .BRANCH_ALU_STALLS(3),
    .BRANCH_LOAD_STALLS(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .pc_write(pcw[1]), .ifid_write(ifw[1]),
    .idex_noop(noop[1]), .ifid_flush(flush[1]),
    .stall_active(sa[1]), .stall_cycles(sc[1])
  );

  hazard_stall_unit #(
    .LOAD_USE_STALLS(0), .BRANCH_ALU_STALLS(0),
    .BRANCH_LOAD_STALLS(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .pc_write(pcw[2]), .ifid_write(ifw[2]),
    .idex_noop(noop[2]), .ifid_flush(flush[2]),
    .stall_active(sa[2]), .stall_cycles(sc[2])
  );

  function automatic bit uses(logic [4:0] rd);
    return (id_use_rs && id_rs != 0 && id_rs == rd) ||
           (id_use_rt && id_rt != 0 && id_rt == rd);
  endfunction

  // Stall cycles the ID instruction needs under configuration i.
  function automatic int need(int i);
    int n = 0;
    bit exm = uses(ex_rd);
    bit mem = uses(mem_rd);
    if (ex_mem_read && exm && !id_is_branch && LU[i] > n) n = LU[i];
    if (id_is_branch && ex_reg_write && !ex_mem_read && exm &&
        BA[i] > n) n = BA[i];
    if (id_is_branch && ex_mem_read && exm && BL[i] > n) n = BL[i];
    if (id_is_branch && mem_mem_read && mem && BL[i] - 1 >= 1 &&
        BL[i] - 1 > n) n = BL[i] - 1;
    return n;
  endfunction

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      out_t e;
      bit   st;
      int   n;
      if (!rst_n) begin
        rem[i] = 0;
        cnt[i] = 0;
        st     = 1'b0;
        e.sa   = 1'b0;
        e.sc   = 0;
        e.flush = 1'b0;
      end else begin
        e.sa = (rem[i] > 0);
        e.sc = PERF ? cnt[i] : 0;
        if (rem[i] > 0) begin
          st = 1'b1;
          rem[i]--;
        end else begin
          n      = need(i);
          st     = (n >= 1);
          rem[i] = st ? n - 1 : 0;
        end
        e.flush = id_branch_taken && !st;
        if (st) cnt[i]++;
      end
      e.pcw  = !st;
      e.ifw  = !st;
      e.noop = st;
      sb.push_back(e);
    end
  endtask

  task automatic chk(int i, string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL u%0d %s got %0h expected %0h at %0t",
               i, nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() >= 3) begin
        for (int i = 0; i < 3; i++) begin
          out_t e;
          e = sb.pop_front();
          chk(i, "pc_write", pcw[i], e.pcw);
          chk(i, "ifid_write", ifw[i], e.ifw);
          chk(i, "idex_noop", noop[i], e.noop);
          chk(i, "ifid_flush", flush[i], e.flush);
          chk(i, "stall_active", sa[i], e.sa);
          chk(i, "stall_cycles", sc[i], e.sc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_use_rs = 0; id_use_rt = 0;
    id_is_branch = 0; id_branch_taken = 0;
    ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0;
  endtask

  task automatic cyc_idle();
    tick(); idle_in(); apply();
  endtask

  task automatic do_reset();
    tick(); rst_n = 0; idle_in(); apply();
    tick(); apply();
    tick(); rst_n = 1; apply();
  endtask

  task automatic load_use();
    tick(); idle_in();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    apply();
  endtask

  task automatic branch_load_ex();
    tick(); idle_in();
    id_is_branch = 1; ex_mem_read = 1; ex_reg_write = 1;
    ex_rd = 8; id_rt = 8; id_use_rt = 1;
    apply();
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    do_reset();

    load_use(); cyc_idle();

    branch_load_ex();
    tick(); apply();
    tick(); apply();
    tick(); idle_in();
    id_is_branch = 1; mem_mem_read = 1; mem_rd = 8;
    id_rt = 8; id_use_rt = 1;
    apply();
    cyc_idle();

    tick(); idle_in();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    apply();
    tick(); idle_in();
    ex_mem_read = 1; ex_rd = 3; id_rt = 3; id_use_rt = 0;
    apply();

    tick(); idle_in();
    id_is_branch = 1; id_branch_taken = 1;
    ex_reg_write = 1; ex_rd = 4; id_rs = 4; id_use_rs = 1;
    mem_mem_read = 1; mem_rd = 4;
    apply();
    for (int k = 0; k < 3; k++) begin tick(); apply(); end
    tick(); idle_in(); id_branch_taken = 1; apply();
    cyc_idle();

    branch_load_ex();
    tick(); rst_n = 0; apply();
    tick(); rst_n = 1; idle_in(); apply();
    cyc_idle();

    do_reset();
    for (int k = 0; k < 3; k++) begin load_use(); cyc_idle(); end
    branch_load_ex();
    tick(); apply();
    cyc_idle();
    @(negedge clk);
    chk(0, "perf_total", sc[0], PERF ? 32'd5 : 32'd0);

    for (int k = 0; k < 3000; k++) begin
      tick();
      rst_n           = ($urandom_range(0, 59) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      mem_rd          = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      id_is_branch    = 1'($urandom_range(0, 1));
      id_branch_taken = 1'($urandom_range(0, 1));
      ex_reg_write    = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      mem_mem_read    = 1'($urandom_range(0, 1));
      apply();
    end

    cyc_idle();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
